adder_array_ctrl: RTL

ADDER_ARRAY_CTRL -- requirements
Module: adder_array_ctrl

---
 rtl/adder_array_ctrl_if.sv | 39 +++
 rtl/adder_array_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/adder_array_ctrl_if.sv
// rtl/adder_array_ctrl_if.sv - request, response and adder-array signal bundle for adder_array_ctrl
interface adder_array_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_mode;
  logic [1:0]  req_lane;
  logic [31:0] req_a0, req_a1, req_a2, req_a3;
  logic [31:0] req_b0, req_b1, req_b2, req_b3;
  logic [2:0]  aa_cmd;
  logic [31:0] aa_ain0, aa_ain1, aa_ain2, aa_ain3;
  logic [31:0] aa_bin0, aa_bin1, aa_bin2, aa_bin3;
  logic [31:0] aa_dout0, aa_dout1, aa_dout2, aa_dout3;
  logic [3:0]  aa_ovf;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_d0, rsp_d1, rsp_d2, rsp_d3;
  logic [3:0]  rsp_ovf;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_mode, req_lane,
    input  req_a0, req_a1, req_a2, req_a3, req_b0, req_b1, req_b2, req_b3,
    output req_ready,
    output aa_cmd, aa_ain0, aa_ain1, aa_ain2, aa_ain3, aa_bin0, aa_bin1, aa_bin2, aa_bin3,
    input  aa_dout0, aa_dout1, aa_dout2, aa_dout3, aa_ovf,
    output rsp_valid, rsp_d0, rsp_d1, rsp_d2, rsp_d3, rsp_ovf, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_mode, req_lane,
    output req_a0, req_a1, req_a2, req_a3, req_b0, req_b1, req_b2, req_b3,
    input  req_ready,
    input  aa_cmd, aa_ain0, aa_ain1, aa_ain2, aa_ain3, aa_bin0, aa_bin1, aa_bin2, aa_bin3,
    output aa_dout0, aa_dout1, aa_dout2, aa_dout3, aa_ovf,
    input  rsp_valid, rsp_d0, rsp_d1, rsp_d2, rsp_d3, rsp_ovf, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/adder_array_ctrl.sv
// rtl/adder_array_ctrl.sv - sequences single/parallel/sweep adds on a 4-lane adder array
// Optional: define ADDER_CTRL_SAT_EN to saturate overflowing lanes to 32'hFFFFFFFF.
module adder_array_ctrl #(
  parameter logic [2:0] IDLE_CMD = 3'd7
) (
  input logic          clk,
  input logic          rst,
  adder_array_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, SWEEP, RESP} state_t;

  state_t      state, state_next;
  logic [1:0]  mode_q, lane_q, cnt_q;
  logic [2:0]  cmd_q, cmd_next;
  logic [31:0] a_q [4];
  logic [31:0] b_q [4];
  logic [31:0] d_q [4];
  logic [3:0]  ovf_q;
  logic        err_q;
  logic [31:0] a_in [4];
  logic [31:0] b_in [4];
  logic [31:0] dout [4];
  logic [31:0] res [4];
  logic        accept;

  assign a_in[0] = bus.req_a0;  assign a_in[1] = bus.req_a1;
  assign a_in[2] = bus.req_a2;  assign a_in[3] = bus.req_a3;
  assign b_in[0] = bus.req_b0;  assign b_in[1] = bus.req_b1;
  assign b_in[2] = bus.req_b2;  assign b_in[3] = bus.req_b3;
  assign dout[0] = bus.aa_dout0; assign dout[1] = bus.aa_dout1;
  assign dout[2] = bus.aa_dout2; assign dout[3] = bus.aa_dout3;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
`ifdef ADDER_CTRL_SAT_EN
      res[i] = bus.aa_ovf[i] ? 32'hFFFF_FFFF : dout[i];
`else
      res[i] = dout[i];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cmd_q <= IDLE_CMD;
    end else begin
      state <= state_next;
      cmd_q <= cmd_next;
    end
  end

  // cmd_next is the command the array sees during the state being entered
  always_comb begin
    state_next = state;
    cmd_next   = cmd_q;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.req_mode)
            2'd0: begin state_next = ISSUE; cmd_next = {1'b0, bus.req_lane}; end
            2'd1: begin state_next = ISSUE; cmd_next = 3'd4; end
            2'd2: begin state_next = SWEEP; cmd_next = 3'd0; end
            default: begin state_next = RESP; cmd_next = IDLE_CMD; end
          endcase
        end
      end
      ISSUE: begin
        state_next = RESP;
        cmd_next   = IDLE_CMD;
      end
      SWEEP: begin
        if (cnt_q == 2'd3) begin
          state_next = RESP;
          cmd_next   = IDLE_CMD;
        end else begin
          cmd_next = {1'b0, cnt_q + 2'd1};
        end
      end
      RESP: begin
        cmd_next = IDLE_CMD;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cmd_next   = IDLE_CMD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 2'd0;
      lane_q <= 2'd0;
      cnt_q  <= 2'd0;
      ovf_q  <= 4'd0;
      err_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= 32'd0;
        b_q[i] <= 32'd0;
        d_q[i] <= 32'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mode_q <= bus.req_mode;
            lane_q <= bus.req_lane;
            cnt_q  <= 2'd0;
            ovf_q  <= 4'd0;
            err_q  <= (bus.req_mode == 2'd3);
            for (int i = 0; i < 4; i++) begin
              a_q[i] <= a_in[i];
              b_q[i] <= b_in[i];
              d_q[i] <= 32'd0;
            end
          end
        end
        ISSUE: begin
          for (int i = 0; i < 4; i++) begin
            if (mode_q == 2'd1 || lane_q == 2'(i)) begin
              d_q[i]   <= res[i];
              ovf_q[i] <= bus.aa_ovf[i];
            end
          end
        end
        SWEEP: begin
          d_q[cnt_q]   <= res[cnt_q];
          ovf_q[cnt_q] <= bus.aa_ovf[cnt_q];
          cnt_q        <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.aa_cmd  = cmd_q;
  assign bus.aa_ain0 = a_q[0]; assign bus.aa_ain1 = a_q[1];
  assign bus.aa_ain2 = a_q[2]; assign bus.aa_ain3 = a_q[3];
  assign bus.aa_bin0 = b_q[0]; assign bus.aa_bin1 = b_q[1];
  assign bus.aa_bin2 = b_q[2]; assign bus.aa_bin3 = b_q[3];

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_d0    = d_q[0];
  assign bus.rsp_d1    = d_q[1];
  assign bus.rsp_d2    = d_q[2];
  assign bus.rsp_d3    = d_q[3];
  assign bus.rsp_ovf   = ovf_q;
  assign bus.rsp_err   = err_q;
endmodule
